regfile: RTL
============

// Module: regfile
// PURPOSE
//  RV32I integer register file: source of the ALU's two operands (rs1, rs2) and sink of the ALU result (rd).
//  Two synchronous read ports, one write port, x0 hardwired to zero.
//  Sits between decode and ALU; read data is registered and launches the execute stage one cycle after request.
// PARAMETERS
//  NREGS      32  number of architectural registers (x0..x31); must be 32 for RV32I
//  AW         5   register address width, log2(NREGS)
//  RST_VAL    0   value loaded into every register on reset
//  (data width is the `XLEN macro from header.vh, 32)
// PORTS
//  i_clk       in   1      CPU clock, all state on rising edge
//  i_rst       in   1      asynchronous active-high reset
//  i_rd_en     in   1      read request: sample rs1/rs2 addresses this cycle
//  i_rs1_addr  in   AW     read port 1 address
//  i_rs2_addr  in   AW     read port 2 address
//  i_wr_en     in   1      write enable for ALU/writeback result
//  i_rd_addr   in   AW     write destination address
//  i_rd_data   in   XLEN   write data (ALU result)
//  o_rs1_data  out  XLEN   registered read data, port 1
//  o_rs2_data  out  XLEN   registered read data, port 2
//  o_rs_valid  out  1      high the cycle after an accepted read request
// BEHAVIOUR
//  Reset (async, i_rst=1): all registers <= RST_VAL; o_rs1_data=o_rs2_data=0; o_rs_valid=0. Holds while asserted;
//   a read or write in flight during reset is discarded; first legal request is the first edge after deassertion.
//  Write: at edge with i_wr_en=1 and i_rd_addr!=0, reg[i_rd_addr] <= i_rd_data. Writes to x0 are ignored.
//  Read: at edge with i_rd_en=1, o_rs1_data <= reg[i_rs1_addr], o_rs2_data <= reg[i_rs2_addr], o_rs_valid <= 1.
//   Latency 1 cycle. Address 0 always returns 0 regardless of write history.
//  Hold: edge with i_rd_en=0 -> o_rs_valid <= 0; o_rs1_data/o_rs2_data keep last value (stall-safe for execute).
//  Both ports may address the same register; both return identical data.
//  Simultaneous read and write to same nonzero address in one cycle: see CONFIGURATION.
//  Write with i_rd_addr=0 and simultaneous read of x0: read returns 0 in all configurations.
//  No internal state machine beyond the storage array and output registers; no X on outputs after reset.
// CONFIGURATION
//  REGFILE_BYPASS_EN defined: write-first. Same-cycle write to the addressed nonzero register forwards i_rd_data
//   to the corresponding output (each port independently); array updated in the same edge.
//  REGFILE_BYPASS_EN undefined: read-first. Output gets the pre-write array value; new value visible from next read.
// TESTING
//  Reset then read x1..x31 with i_rd_en=1 -> each o_rsN_data=0, o_rs_valid=1 one cycle after each request.
//  Write x5=32'hDEADBEEF, next cycle read rs1=5, rs2=5 -> both outputs 32'hDEADBEEF, o_rs_valid=1.
//  Write x0=32'h12345678, then read rs1=0 -> o_rs1_data=0; same-cycle write+read x0 -> 0 too.
//  Preload x7=1; same cycle write x7=32'hA5A5A5A5 and read rs1=7 -> BYPASS_EN: 32'hA5A5A5A5; else 32'h1,
//   then next read -> 32'hA5A5A5A5 in both builds.
//  Read x5 (=32'hDEADBEEF), then i_rd_en=0 for 3 cycles with write x5=0 -> outputs hold 32'hDEADBEEF, o_rs_valid=0.
//  Write x9=32'hFFFFFFFF, assert i_rst mid-cycle (no clock edge) -> outputs 0 immediately; after release read x9 -> 0.

Source files
------------

// File: rtl/regfile.sv
// RV32I integer register file: two registered read ports, one write port,
// x0 hardwired to zero. Read data launches the execute stage one cycle
// after the request.
// Optional feature macro: REGFILE_BYPASS_EN
//   defined   -> write-first: a same-edge write to a read register is forwarded
//   undefined -> read-first: the read returns the pre-write array contents
// Data width comes from `XLEN (32 unless already defined by header.vh).

`ifndef XLEN
`define XLEN 32
`endif

module regfile #(
  parameter int                NREGS   = 32,
  parameter int                AW      = 5,
  parameter logic [`XLEN-1:0]  RST_VAL = {`XLEN{1'b0}}
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_rd_en,
  input  logic [AW-1:0]     i_rs1_addr,
  input  logic [AW-1:0]     i_rs2_addr,
  input  logic              i_wr_en,
  input  logic [AW-1:0]     i_rd_addr,
  input  logic [`XLEN-1:0]  i_rd_data,
  output logic [`XLEN-1:0]  o_rs1_data,
  output logic [`XLEN-1:0]  o_rs2_data,
  output logic              o_rs_valid
);

  localparam logic [`XLEN-1:0] ZERO = {`XLEN{1'b0}};
  localparam logic [AW-1:0]    X0   = {AW{1'b0}};

  logic [`XLEN-1:0] regs_r [NREGS];
  logic [`XLEN-1:0] rs1_data_r;
  logic [`XLEN-1:0] rs2_data_r;
  logic             rs_valid_r;
  logic [`XLEN-1:0] rs1_next_s;
  logic [`XLEN-1:0] rs2_next_s;
  logic             wr_live_s;

  // A write only takes effect when it targets a nonzero register.
  assign wr_live_s = i_wr_en && (i_rd_addr != X0);

  // Port 1 read mux: x0 reads zero; optional forwarding of a same-edge write.
  always_comb begin
    rs1_next_s = ZERO;
    if (i_rs1_addr == X0) begin
      rs1_next_s = ZERO;
    end else begin
      rs1_next_s = regs_r[i_rs1_addr];
`ifdef REGFILE_BYPASS_EN
      if (wr_live_s && (i_rd_addr == i_rs1_addr)) begin
        rs1_next_s = i_rd_data;
      end else begin
        rs1_next_s = regs_r[i_rs1_addr];
      end
`endif
    end
  end

  // Port 2 read mux: same rules as port 1, evaluated independently.
  always_comb begin
    rs2_next_s = ZERO;
    if (i_rs2_addr == X0) begin
      rs2_next_s = ZERO;
    end else begin
      rs2_next_s = regs_r[i_rs2_addr];
`ifdef REGFILE_BYPASS_EN
      if (wr_live_s && (i_rd_addr == i_rs2_addr)) begin
        rs2_next_s = i_rd_data;
      end else begin
        rs2_next_s = regs_r[i_rs2_addr];
      end
`endif
    end
  end

  // Storage array: reset to RST_VAL, x0 never written.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_r[i] <= RST_VAL;
      end
    end else begin
      for (int i = 1; i < NREGS; i++) begin
        if (wr_live_s && (i_rd_addr == AW'(i))) begin
          regs_r[i] <= i_rd_data;
        end
      end
    end
  end

  // Output registers: capture on request, hold data across stalls.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rs1_data_r <= ZERO;
      rs2_data_r <= ZERO;
      rs_valid_r <= 1'b0;
    end else if (i_rd_en) begin
      rs1_data_r <= rs1_next_s;
      rs2_data_r <= rs2_next_s;
      rs_valid_r <= 1'b1;
    end else begin
      rs_valid_r <= 1'b0;
    end
  end

  assign o_rs1_data = rs1_data_r;
  assign o_rs2_data = rs2_data_r;
  assign o_rs_valid = rs_valid_r;

endmodule
